dcache_controller: RTL and testbench



---
 rtl/dcache_pkg.sv | 35 +++
 rtl/dcache_load_align.sv | 31 +++
 rtl/dcache_controller.sv | 154 +++++++++++++++
 tb/tb_dcache_controller.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the MEM-stage data cache: access codes, FSM encoding
// and block/address geometry.
package dcache_pkg;

  localparam int BLOCK_BYTES  = 16;
  localparam int OFFSET_W     = 4;
  localparam int BLOCK_W      = BLOCK_BYTES * 8;
  localparam int BLOCK_ADDR_W = 32 - OFFSET_W;

  localparam logic [3:0] RW_NONE = 4'b0000;
  localparam logic [3:0] RW_LB   = 4'b1000;
  localparam logic [3:0] RW_LH   = 4'b1001;
  localparam logic [3:0] RW_LW   = 4'b1010;
  localparam logic [3:0] RW_LBU  = 4'b1100;
  localparam logic [3:0] RW_LHU  = 4'b1101;
  localparam logic [3:0] RW_SB   = 4'b0100;
  localparam logic [3:0] RW_SH   = 4'b0101;
  localparam logic [3:0] RW_SW   = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } cache_state_e;

  function automatic logic is_load(input logic [3:0] rw);
    return (rw == RW_LB) || (rw == RW_LH) || (rw == RW_LW) ||
           (rw == RW_LBU) || (rw == RW_LHU);
  endfunction

  function automatic logic is_store(input logic [3:0] rw);
    return (rw == RW_SB) || (rw == RW_SH) || (rw == RW_SW);
  endfunction

endpackage

// File: rtl/dcache_load_align.sv
// Picks the addressed byte/half/word out of a cache block and applies the
// sign or zero extension required by the load code.
module dcache_load_align
  import dcache_pkg::*;
(
  input  logic [3:0]          read_write,
  input  logic [OFFSET_W-1:0] offset,
  input  logic [BLOCK_W-1:0]  block,
  output logic [31:0]         data
);

  logic [31:0] word_sel;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    word_sel = block[{offset[3:2], 5'd0} +: 32];
    half_sel = word_sel[{offset[1], 4'd0} +: 16];
    byte_sel = word_sel[{offset[1:0], 3'd0} +: 8];
    data     = '0;
    case (read_write)
      RW_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      RW_LBU:  data = {24'd0, byte_sel};
      RW_LH:   data = {{16{half_sel[15]}}, half_sel};
      RW_LHU:  data = {16'd0, half_sel};
      RW_LW:   data = word_sel;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache for the MEM stage.
// Memory handshake: a request (MEM_READ or MEM_WRITE) is held until the first cycle MEM_BUSYWAIT is low.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int LINES = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [3:0]              READ_WRITE,
  input  logic [31:0]             ADDRESS,
  input  logic [31:0]             WRITEDATA,
  output logic [31:0]             READDATA,
  output logic                    BUSYWAIT,
  output logic                    MEM_READ,
  output logic                    MEM_WRITE,
  output logic [BLOCK_ADDR_W-1:0] MEM_ADDRESS,
  output logic [BLOCK_W-1:0]      MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]      MEM_READDATA,
  input  logic                    MEM_BUSYWAIT,
  output cache_state_e            STATE
);

  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W   = BLOCK_ADDR_W - INDEX_W;

  logic [LINES-1:0]   valid_q, dirty_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [BLOCK_W-1:0] data_q [LINES];

  cache_state_e state_q, state_d;

  logic [TAG_W-1:0]       addr_tag;
  logic [INDEX_W-1:0]     addr_index;
  logic [BLOCK_W-1:0]     line_data;
  logic                   load_acc, store_acc, access, hit;
  logic                   fill_done, write_hit;
  logic [BLOCK_BYTES-1:0] byte_en;
  logic [BLOCK_W-1:0]     store_block, merged_block;
  logic [31:0]            load_data;

  assign addr_tag   = ADDRESS[31 -: TAG_W];
  assign addr_index = ADDRESS[OFFSET_W +: INDEX_W];
  assign line_data  = data_q[addr_index];
  assign load_acc   = is_load(READ_WRITE);
  assign store_acc  = is_store(READ_WRITE);
  assign access     = load_acc || store_acc;
  assign hit        = access && valid_q[addr_index] && (tag_q[addr_index] == addr_tag);
  assign fill_done  = (state_q == ST_ALLOCATE) && !MEM_BUSYWAIT;
  assign write_hit  = (state_q == ST_IDLE) && hit && store_acc;
  assign STATE      = state_q;

  // Store data is replicated across the block; byte_en picks which lanes land.
  always_comb begin
    byte_en     = '0;
    store_block = '0;
    case (READ_WRITE)
      RW_SB: begin
        byte_en     = BLOCK_BYTES'(1) << ADDRESS[3:0];
        store_block = {16{WRITEDATA[7:0]}};
      end
      RW_SH: begin
        byte_en     = BLOCK_BYTES'(3) << {ADDRESS[3:1], 1'b0};
        store_block = {8{WRITEDATA[15:0]}};
      end
      RW_SW: begin
        byte_en     = BLOCK_BYTES'(15) << {ADDRESS[3:2], 2'b00};
        store_block = {4{WRITEDATA}};
      end
      default: ;
    endcase
    merged_block = line_data;
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      if (byte_en[i]) merged_block[i*8 +: 8] = store_block[i*8 +: 8];
    end
  end

  always_comb begin
    state_d       = state_q;
    BUSYWAIT      = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    case (state_q)
      ST_IDLE: begin
        if (access && !hit) begin
          BUSYWAIT = 1'b1;
          state_d  = (valid_q[addr_index] && dirty_q[addr_index]) ? ST_WRITEBACK : ST_ALLOCATE;
        end
      end
      ST_WRITEBACK: begin
        BUSYWAIT      = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tag_q[addr_index], addr_index};
        MEM_WRITEDATA = line_data;
        if (!MEM_BUSYWAIT) state_d = ST_ALLOCATE;
      end
      ST_ALLOCATE: begin
        BUSYWAIT    = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = ADDRESS[31:OFFSET_W];
        if (!MEM_BUSYWAIT) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (RESET) begin
      state_d       = ST_IDLE;
      BUSYWAIT      = 1'b0;
      MEM_READ      = 1'b0;
      MEM_WRITE     = 1'b0;
      MEM_ADDRESS   = '0;
      MEM_WRITEDATA = '0;
    end
  end

  dcache_load_align u_load_align (
    .read_write (READ_WRITE),
    .offset     (ADDRESS[OFFSET_W-1:0]),
    .block      (line_data),
    .data       (load_data)
  );

  assign READDATA = (!RESET && (state_q == ST_IDLE) && hit && load_acc) ? load_data : '0;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      if (fill_done) begin
        valid_q[addr_index] <= 1'b1;
        dirty_q[addr_index] <= 1'b0;
      end else if (write_hit) begin
        dirty_q[addr_index] <= 1'b1;
      end
    end
  end

  // Tag/data arrays carry no reset; a cleared valid bit makes their contents irrelevant.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      if (fill_done) begin
        data_q[addr_index] <= MEM_READDATA;
        tag_q[addr_index]  <= addr_tag;
      end else if (write_hit) begin
        data_q[addr_index] <= merged_block;
      end
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: directed scenarios then random
// traffic, checked against a byte-addressed architectural memory model.
module tb_dcache_controller;
  import dcache_pkg::*;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [3:0]   READ_WRITE;
  logic [31:0]  ADDRESS, WRITEDATA, READDATA;
  logic         BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
  logic [27:0]  MEM_ADDRESS;
  logic [127:0] MEM_WRITEDATA, MEM_READDATA;
  cache_state_e STATE;

  dcache_controller #(.LINES(8)) dut (
    .CLK(CLK), .RESET(RESET), .READ_WRITE(READ_WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
    .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA),
    .MEM_BUSYWAIT(MEM_BUSYWAIT), .STATE(STATE)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0]  exp_q[$];
  logic [127:0] mem  [64];    // backing block store (addresses kept below 0x400)
  logic [7:0]   arch [1024];  // what a program would observe at each byte
  bit           res_valid [8];
  bit           res_dirty [8];
  int           res_blk   [8];
  int           lat;
  int           mem_cnt;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [127:0] arch_block(input int blk);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = arch[blk*16 + i];
    return r;
  endfunction

  task automatic rebuild_arch();
    for (int b = 0; b < 64; b++)
      for (int i = 0; i < 16; i++) arch[b*16 + i] = mem[b][i*8 +: 8];
  endtask

  function automatic logic [31:0] exp_load(input logic [3:0] rw, input logic [31:0] addr);
    int a, h, w;
    a = int'(addr & 32'h3FF);
    h = a & ~1;
    w = a & ~3;
    case (rw)
      RW_LB:   return {{24{arch[a][7]}}, arch[a]};
      RW_LBU:  return {24'd0, arch[a]};
      RW_LH:   return {{16{arch[h+1][7]}}, arch[h+1], arch[h]};
      RW_LHU:  return {16'd0, arch[h+1], arch[h]};
      default: return {arch[w+3], arch[w+2], arch[w+1], arch[w]};
    endcase
  endfunction

  task automatic store_model(input logic [3:0] rw, input logic [31:0] addr, input logic [31:0] wd);
    int a;
    a = int'(addr & 32'h3FF);
    case (rw)
      RW_SB: arch[a] = wd[7:0];
      RW_SH: begin arch[a & ~1] = wd[7:0]; arch[(a & ~1) + 1] = wd[15:8]; end
      default: for (int i = 0; i < 4; i++) arch[(a & ~3) + i] = wd[i*8 +: 8];
    endcase
  endtask

  // ---------------- memory responder + cycle driver ----------------
  task automatic settle();
    #1;
    MEM_BUSYWAIT = !((MEM_READ || MEM_WRITE) && (mem_cnt == lat));
    MEM_READDATA = mem[MEM_ADDRESS[5:0]];
    #1;
  endtask

  task automatic next_cycle();
    if (MEM_READ || MEM_WRITE) begin
      if (!MEM_BUSYWAIT) begin
        if (MEM_WRITE) mem[MEM_ADDRESS[5:0]] = MEM_WRITEDATA;
        mem_cnt = 0;
      end else begin
        mem_cnt++;
      end
    end else begin
      mem_cnt = 0;
    end
    @(posedge CLK);
    settle();
  endtask

  task automatic apply_reset();
    RESET = 1'b1;
    settle();
    check("rst_busywait", BUSYWAIT, 0);
    check("rst_mem_req", {MEM_READ, MEM_WRITE}, 0);
    check("rst_readdata", READDATA, 0);
    check("rst_mem_addr", MEM_ADDRESS, 0);
    check("rst_mem_wdata", MEM_WRITEDATA, 0);
    next_cycle();
    RESET = 1'b0;
    READ_WRITE = RW_NONE;
    settle();
    check("post_rst_state", STATE, ST_IDLE);
    check("post_rst_mem_req", {MEM_READ, MEM_WRITE}, 0);
    check("post_rst_busywait", BUSYWAIT, 0);
    for (int i = 0; i < 8; i++) begin res_valid[i] = 0; res_dirty[i] = 0; end
    rebuild_arch();
  endtask

  task automatic do_access(input logic [3:0] rw, input logic [31:0] addr, input logic [31:0] wd);
    int blk, idx, victim, stall;
    bit hit, wb, saw_w, saw_r, ld, st;
    logic [127:0] victim_data;
    blk = int'(addr[9:4]);
    idx = blk % 8;
    ld  = is_load(rw);
    st  = is_store(rw);
    hit = res_valid[idx] && (res_blk[idx] == blk);
    wb  = !hit && res_valid[idx] && res_dirty[idx];
    victim = res_blk[idx];
    victim_data = arch_block(victim);
    READ_WRITE = rw; ADDRESS = addr; WRITEDATA = wd;
    settle();
    if (!(ld || st)) begin
      check("noacc_busywait", BUSYWAIT, 0);
      check("noacc_readdata", READDATA, 0);
      check("noacc_mem_req", {MEM_READ, MEM_WRITE}, 0);
      next_cycle();
      return;
    end
    if (hit) begin
      check("hit_busywait", BUSYWAIT, 0);
      check("hit_mem_req", {MEM_READ, MEM_WRITE}, 0);
    end else begin
      check("miss_busywait", BUSYWAIT, 1);
      check("miss_readdata", READDATA, 0);
      stall = 0; saw_w = 0; saw_r = 0;
      while (BUSYWAIT && stall < 200) begin
        check("req_exclusive", MEM_READ && MEM_WRITE, 0);
        if (MEM_WRITE && !saw_w) begin
          saw_w = 1;
          check("wb_before_fill", saw_r, 0);
          check("wb_addr", MEM_ADDRESS, victim);
          check("wb_data", MEM_WRITEDATA, victim_data);
        end
        if (MEM_READ && !saw_r) begin
          saw_r = 1;
          check("fill_addr", MEM_ADDRESS, blk);
        end
        stall++;
        next_cycle();
      end
      check("miss_timeout", stall < 200, 1);
      check("wb_seen", saw_w, wb);
      check("fill_seen", saw_r, 1);
      check("miss_penalty", stall, 1 + (wb ? lat + 1 : 0) + lat + 1);
      res_valid[idx] = 1; res_blk[idx] = blk; res_dirty[idx] = 0;
    end
    check("done_busywait", BUSYWAIT, 0);
    if (ld) begin
      exp_q.push_back(exp_load(rw, addr));
      check("load_data", READDATA, exp_q.pop_front());
    end else begin
      check("store_readdata", READDATA, 0);
      store_model(rw, addr, wd);
      res_dirty[idx] = 1;
    end
    next_cycle();
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] codes [12];
  int cyc;

  initial begin
    codes = '{RW_LB, RW_LH, RW_LW, RW_LBU, RW_LHU, RW_SB, RW_SH, RW_SW,
              RW_NONE, 4'b1111, 4'b0111, 4'b1011};
    RESET = 1'b1; READ_WRITE = RW_NONE; ADDRESS = '0; WRITEDATA = '0;
    MEM_BUSYWAIT = 1'b1; MEM_READDATA = '0; mem_cnt = 0; lat = 4;
    for (int b = 0; b < 64; b++) mem[b] = {$urandom, $urandom, $urandom, $urandom};
    mem[4][31:0] = 32'hDEADBEEF;
    @(posedge CLK);
    apply_reset();

    // directed scenarios
    do_access(RW_LW,  32'h40, 0);
    do_access(RW_LB,  32'h43, 0);
    do_access(RW_LBU, 32'h43, 0);
    do_access(RW_LH,  32'h42, 0);
    do_access(RW_SB,  32'h41, 32'h11);
    do_access(RW_LW,  32'h40, 0);
    check("sb_merge_word", {arch[16'h43], arch[16'h42], arch[16'h41], arch[16'h40]}, 32'hDEAD11EF);
    do_access(RW_LW,  32'hC0, 0);
    do_access(RW_SW,  32'h100, 32'hCAFEBABE);
    do_access(RW_LW,  32'h100, 0);

    // reset while a fill is outstanding
    lat = 6;
    READ_WRITE = RW_LW; ADDRESS = 32'h200; WRITEDATA = '0;
    settle();
    cyc = 0;
    while (!MEM_READ && cyc < 50) begin cyc++; next_cycle(); end
    check("reached_allocate", MEM_READ, 1);
    apply_reset();
    do_access(RW_LW, 32'h100, 0);

    // random traffic
    for (int n = 0; n < 300; n++) begin
      lat = $urandom_range(0, 5);
      if ($urandom_range(0, 49) == 0) begin
        READ_WRITE = RW_NONE;
        apply_reset();
      end
      do_access(codes[$urandom_range(0, 11)], $urandom_range(0, 1023), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
